// File: rtl/irig_b_gen_if.sv
// Time-load bus between the upstream time source (master) and the IRIG-B generator (slave).
// The source presents BCD time and pulses time_load; the generator answers with next_req.
interface irig_b_gen_if;
    logic       time_load;
    logic [3:0] second_units;
    logic [2:0] second_tens;
    logic [3:0] minute_units;
    logic [2:0] minute_tens;
    logic [3:0] hour_units;
    logic [1:0] hour_tens;
    logic [3:0] day_units;
    logic [3:0] day_tens;
    logic [1:0] day_hunds;
    logic [3:0] year_units;
    logic [3:0] year_tens;
    logic       next_req;

    modport master (
        output time_load,
        output second_units, second_tens,
        output minute_units, minute_tens,
        output hour_units, hour_tens,
        output day_units, day_tens, day_hunds,
        output year_units, year_tens,
        input  next_req
    );

    modport slave (
        input  time_load,
        input  second_units, second_tens,
        input  minute_units, minute_tens,
        input  hour_units, hour_tens,
        input  day_units, day_tens, day_hunds,
        input  year_units, year_tens,
        output next_req
    );
endinterface

// File: rtl/irig_b_gen.sv
// IRIG-B DC level-shift generator: serialises a shadowed BCD time-of-year into the
// 100-symbol pulse-width-coded frame, one frame per second.
module irig_b_gen #(
    parameter int unsigned SYM_CYCLES = 500_000,
    parameter int unsigned W0_CYCLES  = 100_000,
    parameter int unsigned W1_CYCLES  = 250_000,
    parameter int unsigned WP_CYCLES  = 400_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    irig_b_gen_if.slave       tif,
    output logic              bcode_out,
    output logic              frame_start,
    output logic [6:0]        sym_idx,
    output logic              busy
);

    localparam int unsigned    CW       = $clog2(SYM_CYCLES);
    localparam logic [CW-1:0]  CYC_LAST = CW'(SYM_CYCLES - 1);
    localparam logic [CW-1:0]  W0_W     = CW'(W0_CYCLES);
    localparam logic [CW-1:0]  W1_W     = CW'(W1_CYCLES);
    localparam logic [CW-1:0]  WP_W     = CW'(WP_CYCLES);
    localparam logic [6:0]     SYM_LAST = 7'd99;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef struct packed {
        logic [3:0] su;
        logic [2:0] st;
        logic [3:0] mu;
        logic [2:0] mt;
        logic [3:0] hu;
        logic [1:0] ht;
        logic [3:0] du;
        logic [3:0] dt;
        logic [1:0] dh;
        logic [3:0] yu;
        logic [3:0] yt;
    } bcd_time_t;

    state_t        state, state_n;
    logic [CW-1:0] cyc_cnt, cyc_n;
    logic [6:0]    sym_n;
    logic          enter_frame;
    bcd_time_t     live_time, shadow_time, frame_time, frame_n;
    logic [99:0]   frame_bits;
    logic          is_p;
    logic [CW-1:0] sym_width;
    logic          bcode_n;
    logic          next_req_r;

    assign tif.next_req = next_req_r;

    always_comb begin
        live_time.su = tif.second_units;
        live_time.st = tif.second_tens;
        live_time.mu = tif.minute_units;
        live_time.mt = tif.minute_tens;
        live_time.hu = tif.hour_units;
        live_time.ht = tif.hour_tens;
        live_time.du = tif.day_units;
        live_time.dt = tif.day_tens;
        live_time.dh = tif.day_hunds;
        live_time.yu = tif.year_units;
        live_time.yt = tif.year_tens;
    end

    // Next-state counters; every registered output is derived from these so that
    // outputs describe the cycle being entered, not the one being left.
    always_comb begin
        state_n     = state;
        cyc_n       = cyc_cnt;
        sym_n       = sym_idx;
        enter_frame = 1'b0;
        unique case (state)
            IDLE: begin
                cyc_n = '0;
                sym_n = '0;
                if (en) begin
                    state_n     = RUN;
                    enter_frame = 1'b1;
                end
            end
            RUN: begin
                if (cyc_cnt == CYC_LAST) begin
                    cyc_n = '0;
                    if (sym_idx == SYM_LAST) begin
                        sym_n = '0;
                        if (en) enter_frame = 1'b1;
                        else    state_n     = IDLE;
                    end else begin
                        sym_n = sym_idx + 7'd1;
                    end
                end else begin
                    cyc_n = cyc_cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A load coinciding with the frame entry bypasses the shadow.
    always_comb begin
        frame_n = frame_time;
        if (enter_frame) frame_n = tif.time_load ? live_time : shadow_time;
    end

    always_comb begin
        frame_bits        = '0;
        frame_bits[4:1]   = frame_n.su;
        frame_bits[8:6]   = frame_n.st;
        frame_bits[13:10] = frame_n.mu;
        frame_bits[17:15] = frame_n.mt;
        frame_bits[23:20] = frame_n.hu;
        frame_bits[26:25] = frame_n.ht;
        frame_bits[33:30] = frame_n.du;
        frame_bits[38:35] = frame_n.dt;
        frame_bits[41:40] = frame_n.dh;
        frame_bits[53:50] = frame_n.yu;
        frame_bits[58:55] = frame_n.yt;
    end

    always_comb begin
        is_p = 1'b0;
        case (sym_n)
            7'd0, 7'd9, 7'd19, 7'd29, 7'd39, 7'd49,
            7'd59, 7'd69, 7'd79, 7'd89, 7'd99: is_p = 1'b1;
            default: is_p = 1'b0;
        endcase
    end

    always_comb begin
        if (is_p)                   sym_width = WP_W;
        else if (frame_bits[sym_n]) sym_width = W1_W;
        else                        sym_width = W0_W;
        bcode_n = (state_n == RUN) && (cyc_n < sym_width);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cyc_cnt     <= '0;
            sym_idx     <= '0;
            shadow_time <= '0;
            frame_time  <= '0;
            bcode_out   <= 1'b0;
            frame_start <= 1'b0;
            next_req_r  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cyc_cnt     <= cyc_n;
            sym_idx     <= sym_n;
            frame_time  <= frame_n;
            if (tif.time_load) shadow_time <= live_time;
            bcode_out   <= bcode_n;
            frame_start <= enter_frame;
            next_req_r  <= (state_n == RUN) && (cyc_n == '0) && (sym_n == SYM_LAST);
            busy        <= (state_n == RUN);
        end
    end

endmodule
